// File: rtl/right_barrel_shifter_pkg.sv
// Shared encodings and elaboration helpers for the right barrel shifter.
package right_barrel_shifter_pkg;

   localparam logic OP_SRL = 1'b0;
   localparam logic OP_SRA = 1'b1;

   localparam int IMPL_STAGED = 0;
   localparam int IMPL_BEHAV  = 1;

   function automatic bit width_ok(input int w);
      return (w >= 2) && ((w & (w - 1)) == 0);
   endfunction

endpackage

// File: rtl/right_barrel_shifter_stage.sv
// One mux stage of the staged shifter: shifts right by SHIFT with fill when enabled.
// Purely combinational, no latency, no backpressure.
module right_shift_stage #(
   parameter int WIDTH = 32,
   parameter int SHIFT = 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             en_i,
   input  logic             fill_i,
   output logic [WIDTH-1:0] data_o
);

   assign data_o = en_i ? {{SHIFT{fill_i}}, data_i[WIDTH-1:SHIFT]} : data_i;

endmodule

// File: rtl/right_barrel_shifter.sv
// Logical/arithmetic right shifter with one registered output stage, selectable architecture.
// Latency 1 cycle; no backpressure, accepts one operation every cycle.
module right_barrel_shifter
   import right_barrel_shifter_pkg::*;
#(
   parameter int IMPL  = IMPL_STAGED,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     op,
   input  logic [$clog2(WIDTH)-1:0] amt,
   input  logic [WIDTH-1:0]         a,
   input  logic                     in_valid,
   output logic [WIDTH-1:0]         y,
   output logic                     out_valid
);

   localparam int AW = $clog2(WIDTH);

   logic             fill;
   logic [WIDTH-1:0] shift_res;
   logic [WIDTH-1:0] y_d, y_q;
   logic             vld_q;

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("right_barrel_shifter: WIDTH must be a power of two and >= 2");
   end

   assign fill = (op == OP_SRA) & a[WIDTH-1];

   if (IMPL == IMPL_STAGED) begin : g_staged
      logic [WIDTH-1:0] stg [AW+1];
      assign stg[0] = a;
      // Stage k handles bit k of amt, i.e. a shift by 2^k.
      for (genvar k = 0; k < AW; k++) begin : g_stage
         right_shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
         ) u_stage (
            .data_i (stg[k]),
            .en_i   (amt[k]),
            .fill_i (fill),
            .data_o (stg[k+1])
         );
      end
      assign shift_res = stg[AW];
   end else if (IMPL == IMPL_BEHAV) begin : g_behav
      logic beh_top_unused;
      // Prepending the fill bit lets a signed shift supply zeros or sign copies alike.
      assign {beh_top_unused, shift_res} = $signed({fill, a}) >>> amt;
   end else begin : g_bad_impl
      $error("right_barrel_shifter: IMPL must be 0 or 1");
      assign shift_res = '0;
   end

   assign y_d = in_valid ? shift_res : y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         vld_q <= in_valid;
      end
   end

   assign y         = y_q;
   assign out_valid = vld_q;

endmodule

// File: tb/tb_right_barrel_shifter.sv
// Cross-checks staged and behavioural shifters against an arithmetic reference model.
module tb_right_barrel_shifter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          op;
   logic [4:0]    amt;
   logic [W-1:0]  a;
   logic          in_valid;
   logic [W-1:0]  y_stg, y_beh;
   logic          ov_stg, ov_beh;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   right_barrel_shifter #(.IMPL(0), .WIDTH(W)) u_stg (
      .clk(clk), .rst_n(rst_n), .op(op), .amt(amt), .a(a),
      .in_valid(in_valid), .y(y_stg), .out_valid(ov_stg));

   right_barrel_shifter #(.IMPL(1), .WIDTH(W)) u_beh (
      .clk(clk), .rst_n(rst_n), .op(op), .amt(amt), .a(a),
      .in_valid(in_valid), .y(y_beh), .out_valid(ov_beh));

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Right shift as floor division by 2^amt of the operand read as unsigned (op=0) or signed (op=1).
   function automatic logic [W-1:0] ref_shift(input logic o, input logic [4:0] s, input logic [W-1:0] v);
      longint val, d, q;
      val = longint'(v);
      if (o && v[W-1]) val = val - 64'sd4294967296;
      d = 64'sd1 <<< s;
      if (val < 0) q = (val - (d - 1)) / d;
      else         q = val / d;
      return q[W-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_both(input string tag, input logic [W-1:0] exp_y, input logic exp_v);
      chk({tag, ".y0"}, y_stg, exp_y);
      chk({tag, ".y1"}, y_beh, exp_y);
      chk({tag, ".v0"}, {31'b0, ov_stg}, {31'b0, exp_v});
      chk({tag, ".v1"}, {31'b0, ov_beh}, {31'b0, exp_v});
   endtask

   typedef struct {
      logic        op;
      logic [4:0]  amt;
      logic [31:0] a;
      logic [31:0] exp;
   } vec_t;

   vec_t dir [] = '{
      '{1'b0, 5'd31, 32'h80000000, 32'h00000001},
      '{1'b1, 5'd31, 32'h80000000, 32'hFFFFFFFF},
      '{1'b1, 5'd16, 32'h7FFF0000, 32'h00007FFF},
      '{1'b0, 5'd16, 32'h7FFF0000, 32'h00007FFF},
      '{1'b1, 5'd4,  32'hF0000000, 32'hFF000000},
      '{1'b0, 5'd4,  32'hF0000000, 32'h0F000000},
      '{1'b1, 5'd0,  32'h80000001, 32'h80000001},
      '{1'b0, 5'd31, 32'h7FFFFFFF, 32'h00000000},
      '{1'b1, 5'd31, 32'h7FFFFFFF, 32'h00000000},
      '{1'b0, 5'd1,  32'hAAAAAAAA, 32'h55555555},
      '{1'b1, 5'd1,  32'hAAAAAAAA, 32'hD5555555}
   };

   initial begin
      logic [W-1:0] exp_y;
      logic [W-1:0] q_exp [$];

      rst_n = 1'b0; op = 1'b0; amt = '0; a = '0; in_valid = 1'b0;
      #2;
      chk_both("rst0", '0, 1'b0);
      tick(); tick();
      chk_both("rst1", '0, 1'b0);

      rst_n = 1'b1;
      a = 32'hCAFEF00D; amt = 5'd0; op = 1'b0; in_valid = 1'b1;
      tick();
      chk_both("pre", 32'hCAFEF00D, 1'b1);

      // Asynchronous reset between edges, no clock edge in between.
      #2 rst_n = 1'b0;
      #1;
      chk_both("arst", '0, 1'b0);
      #1 rst_n = 1'b1;

      a = 32'hDEADBEEF; amt = 5'd0; op = 1'b0; in_valid = 1'b1;
      tick();
      chk_both("post_rst", 32'hDEADBEEF, 1'b1);

      foreach (dir[i]) begin
         op = dir[i].op; amt = dir[i].amt; a = dir[i].a; in_valid = 1'b1;
         tick();
         chk_both($sformatf("dir%0d", i), dir[i].exp, 1'b1);
      end

      op = 1'b0; amt = 5'd0; a = 32'h12345678; in_valid = 1'b1;
      tick();
      chk_both("hold0", 32'h12345678, 1'b1);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b0; a = $urandom; amt = 5'($urandom); op = 1'($urandom);
         tick();
         chk_both($sformatf("hold%0d", i + 1), 32'h12345678, 1'b0);
      end

      // Back-to-back stream: results must appear one per cycle in issue order.
      for (int i = 0; i < 8; i++) begin
         op = 1'($urandom); amt = 5'($urandom); a = $urandom; in_valid = 1'b1;
         q_exp.push_back(ref_shift(op, amt, a));
         tick();
         chk_both($sformatf("b2b%0d", i), q_exp.pop_front(), 1'b1);
      end

      exp_y = y_stg === y_beh ? ref_shift(op, amt, a) : '0;
      chk("b2b_last", y_stg, exp_y);

      for (int i = 0; i < 10000; i++) begin
         op = 1'($urandom); amt = 5'($urandom); a = $urandom;
         if (i % 4 == 3) a[W-1] = 1'b1;
         in_valid = ($urandom_range(0, 15) != 0);
         if (in_valid) exp_y = ref_shift(op, amt, a);
         tick();
         chk("rnd.y0", y_stg, exp_y);
         chk("rnd.y1", y_beh, exp_y);
         chk("rnd.v0", {31'b0, ov_stg}, {31'b0, in_valid});
         chk("rnd.xv", {31'b0, ov_beh}, {31'b0, ov_stg});
         chk("rnd.x", y_beh, y_stg);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/right_barrel_shifter.md
Name: right_barrel_shifter

Overview:
- Parameterised right shifter with a registered output.
- Performs logical or arithmetic right shift of a data word by a runtime amount.
- Used in the ALU shift path.
- Two functionally identical micro-architectures, selectable by parameter, so they can be cross-checked against each other in verification.

Parameters:
- IMPL, 0, architecture select. 0 = cascade of log2(WIDTH) mux stages (stage k shifts by 2^k). 1 = single behavioural shift-with-fill expression. Both give bit-identical results and identical latency.
- WIDTH, 32, data width. Must be a power of two and ≥2; any other value is an elaboration error.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- op, input, 1: shift type. 0 = logical (zero fill), 1 = arithmetic (fill with a[WIDTH-1]).
- amt, input, $clog2(WIDTH): shift amount, 0..WIDTH-1.
- a, input, WIDTH: operand.
- in_valid, input, 1: inputs valid this cycle.
- y, output, WIDTH: shifted result, registered.
- out_valid, output, 1: y holds a new result.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, y=0 and out_valid=0 immediately, independent of clk.
- Latency: exactly 1 cycle. Inputs sampled on a clk rising edge with in_valid=1 give the result on y, with out_valid=1, after that edge.
- in_valid=0 at an edge:
  - y holds its previous value.
  - out_valid=0.
- No backpressure; a new operation is accepted every cycle.
- Function: y = a >> amt. The vacated top amt bits are filled with:
  - 0 when op=0;
  - a[WIDTH-1] when op=1.
- Arithmetic/width rules:
  - amt=0: y=a for both op values.
  - amt=WIDTH-1:
    - op=0 gives y = {zeros, a[WIDTH-1]};
    - op=1 gives all bits = a[WIDTH-1].
  - amt is unsigned; no wrap or masking beyond its own width.
- op=1 with a[WIDTH-1]=0 is identical to op=0.
- Shift datapath is purely combinational ahead of the output register. No internal state other than y and out_valid.
- Reset deasserted mid-stream: the first valid edge after release produces a normal result; no stale data appears.
- IMPL=0 and IMPL=1 must match bit-for-bit on every cycle, reset included.

Decomposition:
- Shared package:
  - op encodings: OP_SRL=1'b0, OP_SRA=1'b1;
  - IMPL encodings: IMPL_STAGED=0, IMPL_BEHAV=1.
- One natural sub-module: right_shift_stage, parameters WIDTH and SHIFT.
  - Inputs: data, enable bit, fill bit.
  - Output: data shifted right by SHIFT with fill when enable=1, otherwise data unchanged.
  - Instantiated log2(WIDTH) times under IMPL=0.
- Top level contains:
  - fill-bit generation (op & a[WIDTH-1]);
  - IMPL generate-select;
  - output register with valid.

Test Plan (WIDTH=32, run with both IMPL=0 and IMPL=1, plus a dual-instance compare):
- Reset: assert rst_n=0 between clock edges -> y=0 and out_valid=0 without waiting for an edge. Release, apply a=32'hDEADBEEF, amt=0, op=0, in_valid=1 -> next cycle y=32'hDEADBEEF, out_valid=1.
- Logical shift: a=32'h80000000, amt=31, op=0 -> y=32'h00000001. Same inputs with op=1 -> y=32'hFFFFFFFF.
- Arithmetic, positive operand: a=32'h7FFF0000, amt=16, op=1 -> y=32'h00007FFF. Same inputs with op=0 -> same result.
- Arithmetic, negative operand: a=32'hF0000000, amt=4, op=1 -> y=32'hFF000000. Same inputs with op=0 -> y=32'h0F000000.
- Valid/hold: valid op producing 32'h12345678, then in_valid=0 for 3 cycles with changing a/amt -> y stays 32'h12345678, out_valid=0. Back-to-back valid ops -> one result per cycle, in order.
- Random: 10k cycles of random op/amt/a with in_valid=1 -> y matches the reference model 1 cycle later, and the IMPL=0 and IMPL=1 outputs are identical every cycle.
